uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 154 +++++++++++++++
 tb/tb_uart_rx.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8-N-1 UART receiver with 16x oversampling and 3-sample majority vote per bit.
// Optional even-parity bit between data and stop when UART_RX_PARITY_EN is defined.
`timescale 1ns/1ps
module uart_rx #(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_val,
  output logic       frame_err,
  output logic       parity_err
);

  localparam int DIV = (CLK_HZ + BAUD * 8) / (BAUD * 16);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;

  state_t      state, state_next;
  logic        rx_meta, rx_s;
  logic [DW-1:0] div_cnt;
  logic        tick;
  logic [3:0]  os_cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift_reg;
  logic        s7, s8;
  logic        maj, decide, last_os, par_ok;
  logic        load, ferr_set, perr_set, os_run;

  // Synchronizer resets to the idle level so reset release never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of statement order.
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + 1'b1;
  end

  assign tick    = (div_cnt == DIV_LAST);
  assign maj     = (s7 & s8) | (s7 & rx_s) | (s8 & rx_s);
  assign decide  = tick && (os_cnt == 4'd9);
  assign last_os = tick && (os_cnt == 4'd15);

`ifdef UART_RX_PARITY_EN
  logic par_bit;
  logic perr_q;
  assign par_ok     = ~(^shift_reg ^ par_bit);
  assign parity_err = perr_q;
`else
  assign par_ok     = 1'b1;
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_next = state;
    load       = 1'b0;
    ferr_set   = 1'b0;
    perr_set   = 1'b0;
    case (state)
      IDLE:      if (tick && !rx_s) state_next = START;
      START: begin
        if (decide && maj) state_next = IDLE;
        else if (last_os)  state_next = DATA;
      end
      DATA: begin
        if (last_os && bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
          state_next = PARITY;
`else
          state_next = STOP;
`endif
        end
      end
      PARITY:    if (last_os) state_next = STOP;
      STOP: begin
        if (decide) begin
          // A good stop bit ends the frame at mid-bit to absorb baud mismatch.
          if (maj) begin
            load       = par_ok;
            perr_set   = !par_ok;
            state_next = IDLE;
          end else begin
            ferr_set   = 1'b1;
            perr_set   = !par_ok;
            state_next = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: if (tick && rx_s) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Oversample counter runs only inside a frame and restarts at 0 for each new frame.
  assign os_run = (state != IDLE) && (state != WAIT_HIGH) &&
                  (state_next != IDLE) && (state_next != WAIT_HIGH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      os_cnt    <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      s7        <= 1'b1;
      s8        <= 1'b1;
      rx_data   <= '0;
      rx_val    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (tick) begin
        os_cnt <= os_run ? os_cnt + 1'b1 : 4'd0;
        if (os_cnt == 4'd7) s7 <= rx_s;
        if (os_cnt == 4'd8) s8 <= rx_s;
      end
      if (state == IDLE)                bit_cnt <= '0;
      else if (state == DATA && last_os) bit_cnt <= bit_cnt + 1'b1;
      if (state == DATA && decide) shift_reg <= {maj, shift_reg[7:1]};
      if (load) rx_data <= shift_reg;
      rx_val    <= load;
      frame_err <= ferr_set;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_bit <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      if (state == PARITY && decide) par_bit <= maj;
      perr_q <= perr_set;
    end
  end
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 50 MHz / 115200 baud (27 clocks per tick, 432 per bit).
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int BIT_CLKS = 16 * 27;
`ifdef UART_RX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int LAT_LO = (16 * (FRAME_BITS - 1) + 9) * 27;
  localparam int LAT_HI = LAT_LO + 60;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_val, frame_err, parity_err;

  uart_rx #(.CLK_HZ(50_000_000), .BAUD(115200)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx),
    .rx_data(rx_data), .rx_val(rx_val), .frame_err(frame_err), .parity_err(parity_err)
  );

  always #10 clk = ~clk;

  int n_vec = 0, n_err = 0;
  int cyc = 0;
  int n_val = 0, n_ferr = 0, n_perr = 0, n_both = 0, n_wide = 0;
  int last_val_cyc = 0, frame_start = 0;
  logic [7:0] rxq[$];
  logic prev_val = 1'b0, prev_ferr = 1'b0, prev_perr = 1'b0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_val) begin
        n_val++;
        rxq.push_back(rx_data);
        last_val_cyc = cyc;
      end
      if (frame_err)  n_ferr++;
      if (parity_err) n_perr++;
      if (rx_val && frame_err) n_both++;
      if ((rx_val && prev_val) || (frame_err && prev_ferr) || (parity_err && prev_perr)) n_wide++;
    end
    prev_val  = rx_val;
    prev_ferr = frame_err;
    prev_perr = parity_err;
  end

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle(input int nbits);
    rx = 1'b1;
    repeat (nbits * BIT_CLKS) @(negedge clk);
  endtask

  // glitch_bit >= 0 inverts the line for one tick period around oversample 8 of that frame bit.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_flip,
                            input int glitch_bit);
    logic [10:0] bits;
    bits = '1;
    bits[0]   = 1'b0;
    bits[8:1] = d;
`ifdef UART_RX_PARITY_EN
    bits[9]  = (^d) ^ par_flip;
    bits[10] = stop_bit;
`else
    bits[9]  = stop_bit ^ (par_flip & 1'b0);
`endif
    frame_start = cyc;
    for (int i = 0; i < FRAME_BITS; i++) begin
      rx = bits[i];
      if (i == glitch_bit) begin
        repeat (216) @(negedge clk);
        rx = ~bits[i];
        repeat (27) @(negedge clk);
        rx = bits[i];
        repeat (BIT_CLKS - 243) @(negedge clk);
      end else begin
        repeat (BIT_CLKS) @(negedge clk);
      end
    end
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop_bit;
    int         exp_val;
    int         exp_ferr;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[4];
  int b_val, b_ferr, b_perr, b_q;

  initial begin
    vecs[0] = '{data: 8'h41, stop_bit: 1'b1, exp_val: 1, exp_ferr: 0, exp_data: 8'h41};
    vecs[1] = '{data: 8'h55, stop_bit: 1'b0, exp_val: 0, exp_ferr: 1, exp_data: 8'h41};
    vecs[2] = '{data: 8'h00, stop_bit: 1'b1, exp_val: 1, exp_ferr: 0, exp_data: 8'h00};
    vecs[3] = '{data: 8'h80, stop_bit: 1'b1, exp_val: 1, exp_ferr: 0, exp_data: 8'h80};

    repeat (5) @(negedge clk);
    check("reset rx_data", int'(rx_data), 0);
    check("reset rx_val", int'(rx_val), 0);
    check("reset frame_err", int'(frame_err), 0);
    check("reset parity_err", int'(parity_err), 0);
    rst_n = 1'b1;
    idle(1);

    for (int i = 0; i < 4; i++) begin
      b_val = n_val; b_ferr = n_ferr; b_perr = n_perr;
      send_frame(vecs[i].data, vecs[i].stop_bit, 1'b0, -1);
      idle(1);
      check($sformatf("vec%0d rx_val count", i), n_val - b_val, vecs[i].exp_val);
      check($sformatf("vec%0d frame_err count", i), n_ferr - b_ferr, vecs[i].exp_ferr);
      check($sformatf("vec%0d parity_err count", i), n_perr - b_perr, 0);
      check($sformatf("vec%0d rx_data", i), int'(rx_data), int'(vecs[i].exp_data));
      if (vecs[i].exp_val != 0)
        check($sformatf("vec%0d rx_val latency in window", i),
              int'((last_val_cyc - frame_start) >= LAT_LO && (last_val_cyc - frame_start) <= LAT_HI), 1);
    end

    // Three-tick low glitch on an idle line must be rejected as a false start.
    b_val = n_val; b_ferr = n_ferr;
    rx = 1'b0;
    repeat (81) @(negedge clk);
    idle(1);
    check("glitch rx_val count", n_val - b_val, 0);
    check("glitch frame_err count", n_ferr - b_ferr, 0);
    b_val = n_val;
    send_frame(8'hC3, 1'b1, 1'b0, -1);
    idle(1);
    check("post-glitch rx_val count", n_val - b_val, 1);
    check("post-glitch rx_data", int'(rx_data), 8'hC3);

    // Bad stop bit followed by a 20-bit break, then a clean byte.
    b_val = n_val; b_ferr = n_ferr;
    send_frame(8'h55, 1'b0, 1'b0, -1);
    rx = 1'b0;
    repeat (20 * BIT_CLKS) @(negedge clk);
    idle(1);
    check("break frame_err count", n_ferr - b_ferr, 1);
    check("break rx_val count", n_val - b_val, 0);
    check("break rx_data unchanged", int'(rx_data), 8'hC3);
    b_val = n_val; b_ferr = n_ferr;
    send_frame(8'h0A, 1'b1, 1'b0, -1);
    idle(1);
    check("after break rx_val count", n_val - b_val, 1);
    check("after break rx_data", int'(rx_data), 8'h0A);
    check("after break frame_err count", n_ferr - b_ferr, 0);

    // "1,2\n" with no idle time between frames.
    b_val = n_val; b_q = rxq.size();
    send_frame(8'h31, 1'b1, 1'b0, -1);
    send_frame(8'h2C, 1'b1, 1'b0, -1);
    send_frame(8'h32, 1'b1, 1'b0, -1);
    send_frame(8'h0A, 1'b1, 1'b0, -1);
    idle(1);
    check("b2b rx_val count", n_val - b_val, 4);
    check("b2b byte0", (rxq.size() > b_q + 0) ? int'(rxq[b_q + 0]) : -1, 8'h31);
    check("b2b byte1", (rxq.size() > b_q + 1) ? int'(rxq[b_q + 1]) : -1, 8'h2C);
    check("b2b byte2", (rxq.size() > b_q + 2) ? int'(rxq[b_q + 2]) : -1, 8'h32);
    check("b2b byte3", (rxq.size() > b_q + 3) ? int'(rxq[b_q + 3]) : -1, 8'h0A);

    // One corrupted oversample in data bit 3 (frame bit 4) is outvoted.
    b_val = n_val;
    send_frame(8'hA5, 1'b1, 1'b0, 4);
    idle(1);
    check("majority rx_val count", n_val - b_val, 1);
    check("majority rx_data", int'(rx_data), 8'hA5);

    // Reset in the middle of bit 4 of 0x33 discards the partial byte.
    rx = 1'b0;
    for (int i = 0; i < 4; i++) ;
    begin
      logic [7:0] d;
      d = 8'h33;
      repeat (BIT_CLKS) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        rx = d[i];
        repeat (BIT_CLKS) @(negedge clk);
      end
      rx = d[4];
      repeat (200) @(negedge clk);
    end
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    check("mid-byte reset rx_data", int'(rx_data), 0);
    check("mid-byte reset rx_val", int'(rx_val), 0);
    rst_n = 1'b1;
    b_val = n_val; b_ferr = n_ferr; b_q = rxq.size();
    idle(1);
    send_frame(8'h34, 1'b1, 1'b0, -1);
    idle(1);
    check("post-reset rx_val count", n_val - b_val, 1);
    check("post-reset byte", (rxq.size() > b_q) ? int'(rxq[b_q]) : -1, 8'h34);
    check("post-reset frame_err count", n_ferr - b_ferr, 0);

`ifdef UART_RX_PARITY_EN
    b_val = n_val; b_perr = n_perr;
    send_frame(8'h34, 1'b1, 1'b1, -1);
    idle(1);
    check("parity bad rx_val count", n_val - b_val, 0);
    check("parity bad parity_err count", n_perr - b_perr, 1);
    check("parity bad rx_data unchanged", int'(rx_data), 8'h34);
`else
    check("parity_err never pulses", n_perr, 0);
`endif

    check("rx_val with frame_err overlap", n_both, 0);
    check("strobe wider than one clk", n_wide, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
